// File: rtl/demux_stream_n_if.sv
// Stream bundle for the 1:N demultiplexer: one producer-side input
// channel and N consumer-side output channels, plus drop status.
interface demux_stream_n_if #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 8,
  parameter int SEL_W  = $clog2(N_CH)
);
  logic [DATA_W-1:0]      in;
  logic [SEL_W-1:0]       sel;
  logic                   bcast;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_CH*DATA_W-1:0] y;
  logic [N_CH-1:0]        y_valid;
  logic [N_CH-1:0]        y_ready;
  logic                   err;
  logic [7:0]             drop_cnt;

  // Environment side: drives the producer word and the consumer readies.
  modport master (
    output in, sel, bcast, in_valid, y_ready,
    input  in_ready, y, y_valid, err, drop_cnt
  );

  // Demultiplexer side.
  modport slave (
    input  in, sel, bcast, in_valid, y_ready,
    output in_ready, y, y_valid, err, drop_cnt
  );
endinterface

// File: rtl/demux_stream_n.sv
// Registered 1:N stream demultiplexer: one holding register plus a pending
// mask, with unicast/broadcast delivery and out-of-range drop accounting.
module demux_stream_n #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 8,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  demux_stream_n_if.slave  bus
);

  localparam logic [SEL_W:0]  N_CH_L  = (SEL_W + 1)'(N_CH);
  localparam logic [N_CH-1:0] ONE_HOT = {{(N_CH - 1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] data_q, data_d;
  logic [N_CH-1:0]   pend_q, pend_d;
  logic              err_q, err_d;
  logic [7:0]        drop_q, drop_d;
  logic              accept;
  logic              sel_in_range;

  // Ready when no pending channel is left stalled after this cycle's deliveries.
  assign bus.in_ready  = ((pend_q & ~bus.y_ready) == '0);
  assign accept        = bus.in_valid & bus.in_ready;
  assign sel_in_range  = ({1'b0, bus.sel} < N_CH_L);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    data_d = data_q;
    pend_d = pend_q & ~bus.y_ready;
    err_d  = 1'b0;
    drop_d = drop_q;
    if (accept) begin
      if (bus.bcast) begin
        data_d = bus.in;
        pend_d = '1;
      end else if (sel_in_range) begin
        data_d = bus.in;
        pend_d = ONE_HOT << bus.sel;
      end else begin
        err_d = 1'b1;
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      data_q <= data_d;
      pend_q <= pend_d;
      err_q  <= err_d;
      drop_q <= drop_d;
    end
  end

  assign bus.y_valid  = pend_q;
  assign bus.err      = err_q;
  assign bus.drop_cnt = drop_q;

  // Channels without a pending word read as zero.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign bus.y[i*DATA_W +: DATA_W] = pend_q[i] ? data_q : '0;
  end

endmodule

// File: tb/tb_demux_stream_n.sv
// Bench for demux_stream_n: an 8-channel instance for unicast, back-pressure,
// broadcast and async reset, and a 6-channel instance for out-of-range drops.
module tb_demux_stream_n;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  demux_stream_n_if #(.DATA_W(8), .N_CH(8), .SEL_W(3)) bus8 ();
  demux_stream_n_if #(.DATA_W(8), .N_CH(6), .SEL_W(3)) bus6 ();

  demux_stream_n #(.DATA_W(8), .N_CH(8), .SEL_W(3)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  demux_stream_n #(.DATA_W(8), .N_CH(6), .SEL_W(3)) u_dut6 (
    .clk (clk),
    .rst (rst),
    .bus (bus6)
  );

  typedef struct {
    logic       in_valid;
    logic       bcast;
    logic [2:0] sel;
    logic [7:0] data;
    logic [7:0] y_ready;
    logic       exp_ready;
    logic [7:0] exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  typedef struct {
    logic [7:0] valid;
    logic [7:0] data;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic v, input logic b, input logic [2:0] s,
                              input logic [7:0] d, input logic [7:0] yr, input logic er,
                              input logic [7:0] ev, input logic [7:0] ed);
    vec_t t;
    t.in_valid  = v;
    t.bcast     = b;
    t.sel       = s;
    t.data      = d;
    t.y_ready   = yr;
    t.exp_ready = er;
    t.exp_valid = ev;
    t.exp_data  = ed;
    vecs.push_back(t);
  endfunction

  function automatic logic [63:0] exp_y8(input logic [7:0] v, input logic [7:0] d);
    logic [63:0] r;
    r = '0;
    for (int c = 0; c < 8; c++) if (v[c]) r[c*8 +: 8] = d;
    return r;
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;

    bus8.in_valid = 1'b0; bus8.bcast = 1'b0; bus8.sel = '0; bus8.in = '0; bus8.y_ready = '0;
    bus6.in_valid = 1'b0; bus6.bcast = 1'b0; bus6.sel = '0; bus6.in = '0; bus6.y_ready = '0;

    // Reset values.
    #2 rst = 1'b1;
    #10;
    check("rst_y_valid8",  64'(bus8.y_valid),  64'h0);
    check("rst_y8",        bus8.y,             64'h0);
    check("rst_in_ready8", 64'(bus8.in_ready), 64'h1);
    check("rst_err8",      64'(bus8.err),      64'h0);
    check("rst_drop8",     64'(bus8.drop_cnt), 64'h0);
    check("rst_y_valid6",  64'(bus6.y_valid),  64'h0);
    #10 rst = 1'b0;
    tick();

    // Unicast sweep at full throughput.
    for (int i = 0; i < 8; i++)
      add(1'b1, 1'b0, 3'(i), 8'(8'hA0 + i), 8'hFF, 1'b1, 8'(1 << i), 8'(8'hA0 + i));
    // Back-pressure on channel 3, then release with a new word accepted the same cycle.
    add(1'b1, 1'b0, 3'd3, 8'h5C, 8'hFF, 1'b1, 8'h08, 8'h5C);
    for (int i = 0; i < 4; i++)
      add(1'b1, 1'b0, 3'd5, 8'h77, 8'hF7, 1'b0, 8'h08, 8'h5C);
    add(1'b1, 1'b0, 3'd5, 8'h77, 8'hFF, 1'b1, 8'h20, 8'h77);
    // Broadcast, released one channel per cycle from 7 down to 0.
    add(1'b1, 1'b1, 3'd0, 8'h3E, 8'hFF, 1'b1, 8'hFF, 8'h3E);
    for (int j = 7; j >= 0; j--)
      add(1'b0, 1'b0, 3'd0, 8'h00, 8'(1 << j), (j == 0), 8'((1 << j) - 1), 8'h3E);
    add(1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00);

    foreach (vecs[k]) begin
      bus8.in_valid = vecs[k].in_valid;
      bus8.bcast    = vecs[k].bcast;
      bus8.sel      = vecs[k].sel;
      bus8.in       = vecs[k].data;
      bus8.y_ready  = vecs[k].y_ready;
      #1;
      check($sformatf("v%0d_in_ready", k), 64'(bus8.in_ready), 64'(vecs[k].exp_ready));
      e.valid = vecs[k].exp_valid;
      e.data  = vecs[k].exp_data;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      check($sformatf("v%0d_y_valid", k), 64'(bus8.y_valid), 64'(e.valid));
      check($sformatf("v%0d_y", k),       bus8.y,            exp_y8(e.valid, e.data));
      check($sformatf("v%0d_err", k),     64'(bus8.err),     64'h0);
    end
    bus8.in_valid = 1'b0;

    // Out-of-range unicast on the 6-channel instance.
    bus6.y_ready  = 6'h3F;
    bus6.in_valid = 1'b1;
    bus6.sel      = 3'd6;
    bus6.in       = 8'hAA;
    #1 check("oor6_in_ready", 64'(bus6.in_ready), 64'h1);
    tick();
    check("oor6_y_valid", 64'(bus6.y_valid),  64'h0);
    check("oor6_err",     64'(bus6.err),      64'h1);
    check("oor6_drop",    64'(bus6.drop_cnt), 64'h1);
    bus6.sel = 3'd7;
    #1 check("oor7_in_ready", 64'(bus6.in_ready), 64'h1);
    tick();
    check("oor7_y_valid", 64'(bus6.y_valid),  64'h0);
    check("oor7_y",       64'(bus6.y),        64'h0);
    check("oor7_err",     64'(bus6.err),      64'h1);
    check("oor7_drop",    64'(bus6.drop_cnt), 64'h2);
    bus6.in_valid = 1'b0;
    tick();
    check("oor_idle_err",  64'(bus6.err),      64'h0);
    check("oor_idle_drop", 64'(bus6.drop_cnt), 64'h2);

    // Highest legal channel still delivers.
    bus6.in_valid = 1'b1;
    bus6.sel      = 3'd5;
    bus6.in       = 8'h5A;
    tick();
    check("ch5_y_valid", 64'(bus6.y_valid), 64'h20);
    check("ch5_y",       64'(bus6.y),       64'h0000_5A00_0000_0000);
    check("ch5_err",     64'(bus6.err),     64'h0);

    // 300 further drops: counter saturates instead of wrapping.
    bus6.sel = 3'd6;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 250) check("sat_drop_253", 64'(bus6.drop_cnt), 64'd253);
    end
    check("sat_drop",    64'(bus6.drop_cnt), 64'hFF);
    check("sat_err",     64'(bus6.err),      64'h1);
    check("sat_y_valid", 64'(bus6.y_valid),  64'h0);
    bus6.in_valid = 1'b0;
    tick();
    check("sat_idle_err",  64'(bus6.err),      64'h0);
    check("sat_idle_drop", 64'(bus6.drop_cnt), 64'hFF);

    // Async reset in the middle of a partly delivered broadcast.
    bus8.bcast    = 1'b1;
    bus8.in       = 8'h3E;
    bus8.in_valid = 1'b1;
    bus8.y_ready  = 8'hFF;
    tick();
    bus8.in_valid = 1'b0;
    bus8.bcast    = 1'b0;
    bus8.y_ready  = 8'h0F;
    tick();
    check("pre_rst_y_valid", 64'(bus8.y_valid), 64'hF0);
    check("pre_rst_in_ready", 64'(bus8.in_ready), 64'h0);
    #3 rst = 1'b1;
    #1;
    check("arst_y_valid8",  64'(bus8.y_valid),  64'h0);
    check("arst_y8",        bus8.y,             64'h0);
    check("arst_in_ready8", 64'(bus8.in_ready), 64'h1);
    check("arst_err8",      64'(bus8.err),      64'h0);
    check("arst_drop8",     64'(bus8.drop_cnt), 64'h0);
    check("arst_drop6",     64'(bus6.drop_cnt), 64'h0);
    #3 rst = 1'b0;
    tick();

    bus8.sel      = 3'd2;
    bus8.in       = 8'hC3;
    bus8.in_valid = 1'b1;
    bus8.y_ready  = 8'hFF;
    #1 check("post_rst_in_ready", 64'(bus8.in_ready), 64'h1);
    tick();
    bus8.in_valid = 1'b0;
    check("post_rst_y_valid", 64'(bus8.y_valid), 64'h04);
    check("post_rst_y",       bus8.y,            64'h0000_0000_00C3_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_stream_n.md
# demux_stream_n

Parametrised, registered 1:N stream demultiplexer with valid/ready handshaking on the input and on every output channel. It generalises the combinational 1:8 bit demux to N channels of DATA_W-bit words, and adds a broadcast mode, back-pressure, and out-of-range select detection with a drop counter. It sits between a single producer and N independent consumers, for example a command fan-out to per-lane engines.

## Interface
Parameters:
- DATA_W, 8, width of each data word.
- N_CH, 8, number of output channels (2..16, need not be a power of 2).
- SEL_W, $clog2(N_CH), width of the channel select.

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  reset, asynchronous and active-high.
- in  in  DATA_W  input data word.
- sel  in  SEL_W  destination channel (unicast mode).
- bcast  in  1  1 = deliver word to all N_CH channels, sel ignored.
- in_valid  in  1  producer has a word.
- in_ready  out  1  block accepts a word this cycle.
- y  out  N_CH*DATA_W  channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- y_valid  out  N_CH  per-channel word valid.
- y_ready  in  N_CH  per-channel consumer ready.
- err  out  1  one-cycle pulse on a dropped out-of-range unicast.
- drop_cnt  out  8  saturating count of dropped words.

## Operation
- Storage is one holding register, data_r (DATA_W bits), plus a pending mask, pend (N_CH bits).
- The block has two states:
  - EMPTY: pend == 0.
  - HOLD: pend != 0.
- Accept condition: in_valid & in_ready.
- On accept, when bcast=1: data_r <= in; pend <= all ones.
- On accept, when bcast=0 and sel < N_CH: data_r <= in; pend <= one-hot(sel).
- On accept, when bcast=0 and sel >= N_CH (possible only if N_CH is not a power of 2):
  - the word is consumed (handshake completes) but not stored;
  - pend is only cleared by the delivery rule;
  - err = 1 on the next cycle;
  - drop_cnt increments, saturating at 255.
- Outputs:
  - y_valid = pend.
  - y channel i = data_r when pend[i], else all zeros. Deselected channels read 0, as in the original demux.
- Delivery: pend[i] clears when y_valid[i] & y_ready[i]. Channels clear independently.
- A broadcast word is retired only when every bit of pend has cleared.
- in_ready = ((pend & ~y_ready) == 0).
  - The block accepts when it is empty, or when every pending channel is completing this cycle.
  - When the delivery clear and a new load coincide, the new load wins.
  - The result is full throughput of one word per cycle when consumers are always ready.
- in, sel and bcast are sampled only on accept. Values while in_valid=0 or in_ready=0 are don't-care.
- y_ready on a channel with y_valid=0 has no effect.

## Timing
- Reset values: pend=0, data_r=0, y=0, y_valid=0, in_ready=1, err=0, drop_cnt=0.
- Latency: a word accepted at edge k drives y_valid at edge k (registered). It is visible in the cycle after the accept cycle.
- y and y_valid change only on clk edges or on reset. They never depend combinationally on inputs.
- in_ready depends combinationally on y_ready only, not on in_valid.
- err is high for exactly one cycle per dropped word. Back-to-back drops give err high for consecutive cycles.
- Reset asserted mid-transfer:
  - all pending words are lost;
  - outputs go to their reset values immediately (asynchronously);
  - drop_cnt clears.
- Once asserted, y_valid[i] stays high with y stable until y_ready[i] is sampled high.

## Test plan
- Unicast sweep: N_CH=8, all y_ready=1, send in=8'hA0+i with sel=i for i=0..7 on consecutive cycles.
  - Expect y_valid one-hot 1<<i the cycle after each accept.
  - Expect y channel i = 8'hA0+i and all other channels 0.
  - Expect in_ready held at 1 throughout (8 words in 8 cycles).
- Back-pressure: sel=3, in=8'h5C, y_ready[3]=0 for 4 cycles.
  - Expect y_valid[3]=1 with y stable at 8'h5C for 4 cycles and in_ready=0.
  - Raise y_ready[3]: pend clears and the next word is accepted in the same cycle.
- Broadcast: bcast=1, in=8'h3E; y_ready released one channel per cycle, 7 down to 0.
  - Expect y_valid to go 8'hFF, 8'h7F, …, 8'h00, and in_ready=1 only in the cycle where the last channel completes.
- Out-of-range: N_CH=6, SEL_W=3, sel=6 then sel=7, with in_valid=1.
  - Expect both words accepted and y_valid unchanged at 0.
  - Expect err high for 2 cycles and drop_cnt=2.
  - Force 300 drops: expect drop_cnt=255.
- Async reset mid-broadcast: assert rst with pend=8'hF0 between clock edges.
  - Expect y_valid=0, y=0, err=0, drop_cnt=0 and in_ready=1 immediately.
  - After release, the first accepted word behaves normally.
